seg_msg_checker: RTL and testbench
==================================

Name: seg_msg_checker

Overview:
- Receive-side counterpart of the 7-segment message scroller.
- Samples active-low 7-segment glyphs (g..a, bit 6 = g, 0 = segment lit), one per strobe, and decodes each to a 4-bit character code.
- Tracks the fixed 11-glyph message "HAPPY BDAY " and reports lock, completed messages and errors.
- Used as an on-chip self-check and in benches, fed from the same segment bus that drives the HEX display.

Parameters:
- MSG_LEN, 11, number of glyphs in the expected message.
- CNT_W, 8, width of the msg_count and err_count counters.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of the FSM and both counters.
- seg_valid  in  1  seg carries a new glyph this cycle.
- seg  in  7  active-low segment pattern.
- char_strobe  out  1  one-cycle pulse: char_code/char_known updated.
- char_code  out  4  decoded character.
- char_known  out  1  glyph matched a table entry.
- locked  out  1  a full message has been matched and no mismatch has occurred since.
- msg_done  out  1  one-cycle pulse on completion of each full message.
- err_pulse  out  1  one-cycle pulse on a mismatch while in TRACK or LOCKED.
- msg_count  out  CNT_W  completed messages, wraps.
- err_count  out  CNT_W  mismatches, saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, char_code=0, FSM=HUNT, idx=0.
- Decode table (exact 7-bit match):
  - 1111111→0 BLANK, 0001001→1 H, 0001000→2 A, 0001100→3 P
  - 0010001→4 Y, 0000011→5 B, 0100001→6 D, 0010010→7 S
  - 0000111→8 T, 0100011→9 O, 1000110→10 C, 0101011→11 N
  - Any other pattern: code 15, char_known=0.
- Expected message codes, idx 0..10: 1,2,3,3,4,0,5,6,2,4,0.
- Latency: seg_valid at edge t → char_strobe/char_code/char_known at t+1.
  - FSM, counters and pulses update on the same edge, from the combinational decode of seg.
  - char_code holds its value between strobes.
- FSM states HUNT, TRACK, LOCKED; idx = index of the next expected glyph. No transitions without seg_valid.
- HUNT:
  - code 1 (H) → TRACK, idx=1.
  - Otherwise stay; no error counted.
- TRACK, glyph == msg[idx]:
  - idx < MSG_LEN-1: idx++.
  - idx == MSG_LEN-1: msg_done=1, msg_count++, → LOCKED, idx=0.
- TRACK, mismatch (unknown glyph included):
  - err_pulse=1, err_count++ (saturating).
  - If code==1 → TRACK, idx=1; else → HUNT, idx=0.
- LOCKED:
  - Same comparison rules as TRACK; idx wraps 10→0 with msg_done each time and stays LOCKED.
  - On mismatch: locked drops on the same edge, error counted, restart rule as in TRACK.
- locked = (state==LOCKED), registered.
- msg_count wraps from 2^CNT_W-1 to 0.
- err_count holds at 2^CNT_W-1; err_pulse still fires when saturated.
- clr:
  - FSM→HUNT, idx=0, counters=0, pulses=0; char_code/char_known keep their values.
  - clr and seg_valid in the same cycle: clr wins, glyph dropped, no char_strobe.
- rst_n asserted mid-message: immediate return to reset values; after release, tracking restarts from HUNT.
- Back-to-back seg_valid on every cycle is supported at full rate.

Optional Feature:
- SEG_ASCII_EN defined:
  - Extra output char_ascii (8 bits), registered with char_code.
  - Maps 0→0x20, 1..11→'H','A','P','Y','B','D','S','T','O','C','N', 15→'?' (0x3F).
  - Reset value 0x00.
- SEG_ASCII_EN undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then one seg_valid with 0001001 → next cycle char_strobe=1, char_code=1, char_known=1; FSM in TRACK (locked=0).
- Full message H,A,P,P,Y,BLANK,B,D,A,Y,BLANK on consecutive cycles → msg_done pulses once, on the cycle after the 11th glyph; locked=1, msg_count=1, err_count=0.
- Message sent 3 times back-to-back → msg_done 3 pulses, 11 cycles apart; msg_count=3; locked stays 1 throughout.
- While locked, send H,A,then 0000000 (unknown) → char_code=15, char_known=0, err_pulse=1, locked=0, err_count=1; a following H → TRACK, idx=1.
- CNT_W=2: 5 mismatches in TRACK → err_count 1,2,3,3,3. Send 5 full messages → msg_count ends at 1 after wrapping.
- clr and seg_valid asserted together mid-message → no char_strobe; counters 0; FSM in HUNT. Assert rst_n=0 asynchronously mid-message → outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/seg_msg_checker.sv
// seg_msg_checker: decodes active-low 7-segment glyphs into character codes
// and tracks the repeating message "HAPPY BDAY ". It reports lock,
// completed messages and mismatches.
// Optional feature: define SEG_ASCII_EN to add the char_ascii output.
module seg_msg_checker #(
  parameter int MSG_LEN = 11,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             seg_valid,
  input  logic [6:0]       seg,
  output logic             char_strobe,
  output logic [3:0]       char_code,
  output logic             char_known,
  output logic             locked,
  output logic             msg_done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count
`ifdef SEG_ASCII_EN
  ,
  output logic [7:0]       char_ascii
`endif
);

  localparam int IDX_W = $clog2(MSG_LEN);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [3:0]         dec_code;
  logic               dec_known;
  logic [3:0]         exp_code;
  logic               done_next, err_next;

  // Combinational glyph decode: exact match against the character table
  always_comb begin
    dec_code  = 4'd15;
    dec_known = 1'b1;
    case (seg)
      7'b1111111: dec_code = 4'd0;
      7'b0001001: dec_code = 4'd1;
      7'b0001000: dec_code = 4'd2;
      7'b0001100: dec_code = 4'd3;
      7'b0010001: dec_code = 4'd4;
      7'b0000011: dec_code = 4'd5;
      7'b0100001: dec_code = 4'd6;
      7'b0010010: dec_code = 4'd7;
      7'b0000111: dec_code = 4'd8;
      7'b0100011: dec_code = 4'd9;
      7'b1000110: dec_code = 4'd10;
      7'b0101011: dec_code = 4'd11;
      default:    dec_known = 1'b0;
    endcase
  end

  // Expected character code of the message at the current index
  always_comb begin
    exp_code = 4'd0;
    case (idx)
      IDX_W'(0):  exp_code = 4'd1;
      IDX_W'(1):  exp_code = 4'd2;
      IDX_W'(2):  exp_code = 4'd3;
      IDX_W'(3):  exp_code = 4'd3;
      IDX_W'(4):  exp_code = 4'd4;
      IDX_W'(5):  exp_code = 4'd0;
      IDX_W'(6):  exp_code = 4'd5;
      IDX_W'(7):  exp_code = 4'd6;
      IDX_W'(8):  exp_code = 4'd2;
      IDX_W'(9):  exp_code = 4'd4;
      IDX_W'(10): exp_code = 4'd0;
      default:    exp_code = 4'd0;
    endcase
  end

  // Next-state logic; an H always restarts tracking at index 1
  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (seg_valid) begin
      case (state)
        HUNT: begin
          if (dec_code == 4'd1) begin
            state_next = TRACK;
            idx_next   = IDX_W'(1);
          end
        end
        TRACK, LOCKED: begin
          if (dec_known && dec_code == exp_code) begin
            if (idx == IDX_W'(MSG_LEN - 1)) begin
              done_next  = 1'b1;
              state_next = LOCKED;
              idx_next   = '0;
            end else begin
              idx_next = idx + IDX_W'(1);
            end
          end else begin
            err_next = 1'b1;
            if (dec_code == 4'd1) begin
              state_next = TRACK;
              idx_next   = IDX_W'(1);
            end else begin
              state_next = HUNT;
              idx_next   = '0;
            end
          end
        end
        default: begin
          state_next = HUNT;
          idx_next   = '0;
        end
      endcase
    end
  end

  // State register; clr returns tracking to HUNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      idx   <= '0;
    end else if (clr) begin
      state <= HUNT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  assign locked = (state == LOCKED);

  // Pulses and counters; msg_count wraps, err_count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_done  <= 1'b0;
      err_pulse <= 1'b0;
      msg_count <= '0;
      err_count <= '0;
    end else if (clr) begin
      msg_done  <= 1'b0;
      err_pulse <= 1'b0;
      msg_count <= '0;
      err_count <= '0;
    end else begin
      msg_done  <= done_next;
      err_pulse <= err_next;
      if (done_next)
        msg_count <= msg_count + CNT_W'(1);
      if (err_next && err_count != {CNT_W{1'b1}})
        err_count <= err_count + CNT_W'(1);
    end
  end

  // Decoded character register; holds its value between strobes and across clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_strobe <= 1'b0;
      char_code   <= 4'd0;
      char_known  <= 1'b0;
    end else begin
      char_strobe <= seg_valid && !clr;
      if (seg_valid && !clr) begin
        char_code  <= dec_code;
        char_known <= dec_known;
      end
    end
  end

`ifdef SEG_ASCII_EN
  logic [7:0] ascii_next;

  // ASCII translation of the decoded code
  always_comb begin
    ascii_next = 8'h3F;
    case (dec_code)
      4'd0:  ascii_next = 8'h20;
      4'd1:  ascii_next = "H";
      4'd2:  ascii_next = "A";
      4'd3:  ascii_next = "P";
      4'd4:  ascii_next = "Y";
      4'd5:  ascii_next = "B";
      4'd6:  ascii_next = "D";
      4'd7:  ascii_next = "S";
      4'd8:  ascii_next = "T";
      4'd9:  ascii_next = "O";
      4'd10: ascii_next = "C";
      4'd11: ascii_next = "N";
      default: ascii_next = 8'h3F;
    endcase
  end

  // ASCII register, updated together with char_code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      char_ascii <= 8'h00;
    else if (seg_valid && !clr)
      char_ascii <= ascii_next;
  end
`endif

endmodule

// File: tb/tb_seg_msg_checker.sv
// Testbench for seg_msg_checker. A default-width instance and a CNT_W=2
// instance share the same stimulus; the small one exercises counter limits.
module tb_seg_msg_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       seg_valid = 1'b0;
  logic [6:0] seg = 7'b1111111;

  logic       char_strobe, char_known, locked, msg_done, err_pulse;
  logic [3:0] char_code;
  logic [7:0] msg_count, err_count;

  logic       s_char_strobe, s_char_known, s_locked, s_msg_done, s_err_pulse;
  logic [3:0] s_char_code;
  logic [1:0] s_msg_count, s_err_count;

`ifdef SEG_ASCII_EN
  logic [7:0] char_ascii, s_char_ascii;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] MSG_SEG [11] = '{
    7'b0001001, 7'b0001000, 7'b0001100, 7'b0001100, 7'b0010001, 7'b1111111,
    7'b0000011, 7'b0100001, 7'b0001000, 7'b0010001, 7'b1111111
  };
  localparam logic [6:0] GLYPH_H   = 7'b0001001;
  localparam logic [6:0] GLYPH_A   = 7'b0001000;
  localparam logic [6:0] GLYPH_P   = 7'b0001100;
  localparam logic [6:0] GLYPH_T   = 7'b0000111;
  localparam logic [6:0] GLYPH_BAD = 7'b0000000;

  seg_msg_checker #(.MSG_LEN(11), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .seg_valid(seg_valid), .seg(seg),
    .char_strobe(char_strobe), .char_code(char_code), .char_known(char_known),
    .locked(locked), .msg_done(msg_done), .err_pulse(err_pulse),
    .msg_count(msg_count), .err_count(err_count)
`ifdef SEG_ASCII_EN
    , .char_ascii(char_ascii)
`endif
  );

  seg_msg_checker #(.MSG_LEN(11), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .clr(clr), .seg_valid(seg_valid), .seg(seg),
    .char_strobe(s_char_strobe), .char_code(s_char_code), .char_known(s_char_known),
    .locked(s_locked), .msg_done(s_msg_done), .err_pulse(s_err_pulse),
    .msg_count(s_msg_count), .err_count(s_err_count)
`ifdef SEG_ASCII_EN
    , .char_ascii(s_char_ascii)
`endif
  );

  always #5 clk = ~clk;

  // Present one glyph for one clock; outputs are valid on return
  task automatic send(input logic [6:0] g);
    seg = g;
    seg_valid = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({char_strobe, char_code, char_known, locked, msg_done, err_pulse} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0",
               {char_strobe, char_code, char_known, locked, msg_done, err_pulse});
    end
    checks++;
    if ({msg_count, err_count} !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", msg_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_glyph();
    send(GLYPH_H);
    checks++;
    if ({char_strobe, char_code, char_known, locked} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL first_glyph: got strobe=%b code=%0d known=%b locked=%b expected 1 1 1 0",
               char_strobe, char_code, char_known, locked);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({char_strobe, char_code} !== {1'b0, 4'd1}) begin
      errors++;
      $display("[TB] FAIL code_hold: got strobe=%b code=%0d expected 0 1", char_strobe, char_code);
    end
  endtask

  task automatic test_full_message();
    pulse_clr();
    for (int i = 0; i < 11; i++) begin
      send(MSG_SEG[i]);
      checks++;
      if ({msg_done, err_pulse} !== {(i == 10), 1'b0}) begin
        errors++;
        $display("[TB] FAIL full_msg_pulse[%0d]: got done=%b err=%b expected %b 0",
                 i, msg_done, err_pulse, (i == 10));
      end
    end
    checks++;
    if ({locked, msg_count, err_count} !== {1'b1, 8'd1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL full_msg_state: got locked=%b msg=%0d err=%0d expected 1 1 0",
               locked, msg_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    pulse_clr();
    for (int i = 0; i < 33; i++) begin
      send(MSG_SEG[i % 11]);
      if (msg_done) dones++;
      checks++;
      if ({msg_done, locked} !== {(i % 11 == 10), (i >= 10)}) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: got done=%b locked=%b expected %b %b",
                 i, msg_done, locked, (i % 11 == 10), (i >= 10));
      end
    end
    checks++;
    if (dones !== 3 || msg_count !== 8'd3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got pulses=%0d msg=%0d expected 3 3", dones, msg_count);
    end
  endtask

  task automatic test_mismatch_locked();
    send(GLYPH_H);
    send(GLYPH_A);
    send(GLYPH_BAD);
    checks++;
    if ({char_code, char_known, err_pulse, locked} !== {4'd15, 1'b0, 1'b1, 1'b0}
        || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL locked_mismatch: got code=%0d known=%b err=%b locked=%b cnt=%0d expected 15 0 1 0 1",
               char_code, char_known, err_pulse, locked, err_count);
    end
    send(GLYPH_H);
    checks++;
    if ({char_code, err_pulse, locked} !== {4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL restart_h: got code=%0d err=%b locked=%b expected 1 0 0",
               char_code, err_pulse, locked);
    end
    for (int i = 1; i < 11; i++) send(MSG_SEG[i]);
    checks++;
    if ({msg_done, locked, msg_count} !== {1'b1, 1'b1, 8'd4}) begin
      errors++;
      $display("[TB] FAIL resync: got done=%b locked=%b msg=%0d expected 1 1 4",
               msg_done, locked, msg_count);
    end
  endtask

  task automatic test_counter_limits();
    int exp_s;
    pulse_clr();
    for (int k = 0; k < 5; k++) begin
      send(GLYPH_H);
      send(GLYPH_T);
      exp_s = (k + 1 > 3) ? 3 : k + 1;
      checks++;
      if (s_err_count !== 2'(exp_s) || s_err_pulse !== 1'b1 || err_count !== 8'(k + 1)) begin
        errors++;
        $display("[TB] FAIL err_sat[%0d]: got small=%0d pulse=%b big=%0d expected %0d 1 %0d",
                 k, s_err_count, s_err_pulse, err_count, exp_s, k + 1);
      end
    end
    pulse_clr();
    for (int i = 0; i < 55; i++) send(MSG_SEG[i % 11]);
    checks++;
    if (s_msg_count !== 2'd1 || msg_count !== 8'd5) begin
      errors++;
      $display("[TB] FAIL msg_wrap: got small=%0d big=%0d expected 1 5", s_msg_count, msg_count);
    end
  endtask

  task automatic test_clr();
    send(GLYPH_H);
    send(GLYPH_A);
    send(GLYPH_P);
    seg = GLYPH_P;
    seg_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    clr = 1'b0;
    checks++;
    if ({char_strobe, locked, char_code} !== {1'b0, 1'b0, 4'd3} || msg_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clr_with_valid: got strobe=%b locked=%b code=%0d msg=%0d expected 0 0 3 0",
               char_strobe, locked, char_code, msg_count);
    end
    send(GLYPH_A);
    checks++;
    if ({char_strobe, err_pulse, err_count} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL clr_hunt: got strobe=%b err=%b cnt=%0d expected 1 0 0",
               char_strobe, err_pulse, err_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 11; i++) send(MSG_SEG[i]);
    send(GLYPH_H);
    send(GLYPH_A);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({char_strobe, char_code, char_known, locked} !== 7'd0 || msg_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got strobe=%b code=%0d known=%b locked=%b msg=%0d expected all 0",
               char_strobe, char_code, char_known, locked, msg_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(GLYPH_P);
    checks++;
    if ({err_pulse, char_code, locked} !== {1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_reset_hunt: got err=%b code=%0d locked=%b expected 0 3 0",
               err_pulse, char_code, locked);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_first_glyph();
    test_full_message();
    test_back_to_back();
    test_mismatch_locked();
    test_counter_limits();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
